// File: rtl/rpsc_pkg.sv
// -----------------------------------------------------------------------------
// rpsc_pkg
// Shared definitions for the RPSC card-3 input conditioner:
//   - channel bit map of the field input vector,
//   - default integrator width / full-scale values (normal and test mode),
//   - default low-pass mask (which channels are integrated vs. sync-only),
//   - channel vector type and integrator direction type.
// -----------------------------------------------------------------------------
package rpsc_pkg;

   localparam int unsigned RPSC_N_CH = 32'd14;

   // Channel bit map of raw_in / filt_out
   localparam int unsigned CH_I4_U_G2_LOW     = 32'd0;
   localparam int unsigned CH_I7_U_G2_HIGH    = 32'd1;
   localparam int unsigned CH_I59_DR_AMP      = 32'd2;
   localparam int unsigned CH_I12_BRK_CLOSED  = 32'd3;
   localparam int unsigned CH_I15_BRK_OPEN    = 32'd4;
   localparam int unsigned CH_I18_FAN_OK      = 32'd5;
   localparam int unsigned CH_I21_DOOR_CLOSED = 32'd6;
   localparam int unsigned CH_I24_ESTOP_OK    = 32'd7;
   localparam int unsigned CH_I27_G2_PS_ACT   = 32'd8;
   localparam int unsigned CH_I30_TEMP_OK     = 32'd9;
   localparam int unsigned CH_I33_WATER_OK    = 32'd10;
   localparam int unsigned CH_I36_VAC_OK      = 32'd11;
   localparam int unsigned CH_I41_INTLK_EXT   = 32'd12;
   localparam int unsigned CH_I45_SPARE       = 32'd13;

   // Integrator defaults: ~10 ms at 781.25 kHz in the field build,
   // a short 8-step window for simulation builds.
   localparam int unsigned RPSC_CNT_W_DEF       = 32'd13;
   localparam int unsigned RPSC_FILT_TARGET_DEF = 32'd7812;
   localparam int unsigned RPSC_CNT_W_TEST      = 32'd4;
   localparam int unsigned RPSC_FILT_TARGET_TEST = 32'd8;

   // G2_PS_ACT (bit 8) and DR_AMP (bit 2) are integrated, the rest bypass
   localparam logic [RPSC_N_CH-1:0] RPSC_LPF_MASK_DEF = 14'h0104;

   typedef logic [RPSC_N_CH-1:0] rpsc_ch_vec_t;

   // Direction of the most recent integrator step
   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } rpsc_dir_e;

   // One-hot channel vector for a given channel index
   function automatic rpsc_ch_vec_t ch_bit(input int unsigned idx);
      rpsc_ch_vec_t v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rpsc_lpf_channel.sv
// -----------------------------------------------------------------------------
// rpsc_lpf_channel
// One conditioner channel: 2-flop synchroniser, saturating up/down integrator
// with hysteresis on its end points, rise/fall strobes and a sticky chatter
// flag. With FILTERED=0 the channel is a pure synchroniser plus one output
// register; integrator and chatter logic stay idle at zero.
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   raw          unsynchronised field input
//   chatter_clr  one-cycle clear request for the chatter flag
//   filt         conditioned level (registered)
//   rise_stb     one-cycle pulse on filt 0->1 (registered)
//   fall_stb     one-cycle pulse on filt 1->0 (registered)
//   chatter      sticky direction-reversal flag (registered)
// -----------------------------------------------------------------------------
module rpsc_lpf_channel
   import rpsc_pkg::*;
#(
   parameter int unsigned CNT_W       = 32'd13,
   parameter int unsigned FILT_TARGET = 32'd7812,
   parameter bit          FILTERED    = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   input  logic chatter_clr,
   output logic filt,
   output logic rise_stb,
   output logic fall_stb,
   output logic chatter
);

   localparam logic [CNT_W-1:0] TARGET_C = CNT_W'(FILT_TARGET);
   localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

   logic             s1_r;
   logic             s2_r;
   logic [CNT_W-1:0] cnt_r;
   rpsc_dir_e        dir_r;
   logic             filt_r;
   logic             rise_r;
   logic             fall_r;
   logic             chatter_r;

   logic [CNT_W-1:0] cnt_next_s;
   rpsc_dir_e        dir_next_s;
   logic             filt_next_s;
   logic             chatter_set_s;
   logic             chatter_next_s;
   logic             dir_is_up_s;

   assign dir_is_up_s = (dir_r == DIR_UP);

   // Integrator step, hysteresis level and chatter detection
   always_comb begin
      cnt_next_s    = cnt_r;
      dir_next_s    = dir_r;
      filt_next_s   = filt_r;
      chatter_set_s = 1'b0;
      if (FILTERED) begin
         if (s2_r && (cnt_r < TARGET_C)) begin
            cnt_next_s = cnt_r + ONE_C;
            dir_next_s = DIR_UP;
         end else if (!s2_r && (cnt_r != ZERO_C)) begin
            cnt_next_s = cnt_r - ONE_C;
            dir_next_s = DIR_DOWN;
         end else begin
            cnt_next_s = cnt_r;
            dir_next_s = dir_r;
         end
         // Level only changes when the integrator reaches an end point
         if (cnt_next_s == TARGET_C) begin
            filt_next_s = 1'b1;
         end else if (cnt_next_s == ZERO_C) begin
            filt_next_s = 1'b0;
         end else begin
            filt_next_s = filt_r;
         end
         // Input reversed while integrating: the line is bouncing
         if ((cnt_r != ZERO_C) && (cnt_r < TARGET_C) && (s2_r != dir_is_up_s)) begin
            chatter_set_s = 1'b1;
         end else begin
            chatter_set_s = 1'b0;
         end
      end else begin
         cnt_next_s    = ZERO_C;
         dir_next_s    = DIR_DOWN;
         filt_next_s   = s2_r;
         chatter_set_s = 1'b0;
      end
      // A new chatter event beats a simultaneous clear request
      chatter_next_s = chatter_set_s | (chatter_r & ~chatter_clr);
   end

   // Synchroniser, integrator state and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_r      <= 1'b0;
         s2_r      <= 1'b0;
         cnt_r     <= ZERO_C;
         dir_r     <= DIR_DOWN;
         filt_r    <= 1'b0;
         rise_r    <= 1'b0;
         fall_r    <= 1'b0;
         chatter_r <= 1'b0;
      end else begin
         s1_r      <= raw;
         s2_r      <= s1_r;
         cnt_r     <= cnt_next_s;
         dir_r     <= dir_next_s;
         filt_r    <= filt_next_s;
         rise_r    <= filt_next_s & ~filt_r;
         fall_r    <= ~filt_next_s & filt_r;
         chatter_r <= chatter_next_s;
      end
   end

   assign filt     = filt_r;
   assign rise_stb = rise_r;
   assign fall_stb = fall_r;
   assign chatter  = chatter_r;

endmodule

// File: rtl/rpsc_input_conditioner.sv
// -----------------------------------------------------------------------------
// rpsc_input_conditioner
// Front-end conditioning for the RPSC card-3 field inputs. Each channel is
// synchronised; channels selected by LPF_MASK are additionally integrated so
// short disturbances never reach the alarm/permission logic. All outputs are
// registered inside the channel instances.
// Ports:
//   clk          system clock (781.25 kHz)
//   reset        asynchronous active-low reset
//   raw_in       unsynchronised field inputs (bit map in rpsc_pkg)
//   chatter_clr  per-channel one-cycle chatter clear
//   filt_out     conditioned levels to card-3 inputs
//   rise_stb     per-channel one-cycle 0->1 pulse
//   fall_stb     per-channel one-cycle 1->0 pulse
//   chatter      per-channel sticky chatter flags
// -----------------------------------------------------------------------------
module rpsc_input_conditioner
   import rpsc_pkg::*;
#(
   parameter int unsigned     N_CH        = RPSC_N_CH,
   parameter int unsigned     CNT_W       = RPSC_CNT_W_DEF,
   parameter int unsigned     FILT_TARGET = RPSC_FILT_TARGET_DEF,
   parameter logic [N_CH-1:0] LPF_MASK    = RPSC_LPF_MASK_DEF,
   parameter bit              TEST_MODE   = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] raw_in,
   input  logic [N_CH-1:0] chatter_clr,
   output logic [N_CH-1:0] filt_out,
   output logic [N_CH-1:0] rise_stb,
   output logic [N_CH-1:0] fall_stb,
   output logic [N_CH-1:0] chatter
);

   // Simulation builds shrink the integrator to an 8-step window
   localparam int unsigned EFF_CNT_W  = TEST_MODE ? RPSC_CNT_W_TEST : CNT_W;
   localparam int unsigned EFF_TARGET = TEST_MODE ? RPSC_FILT_TARGET_TEST : FILT_TARGET;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      rpsc_lpf_channel #(
         .CNT_W       (EFF_CNT_W),
         .FILT_TARGET (EFF_TARGET),
         .FILTERED    (LPF_MASK[k])
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .raw         (raw_in[k]),
         .chatter_clr (chatter_clr[k]),
         .filt        (filt_out[k]),
         .rise_stb    (rise_stb[k]),
         .fall_stb    (fall_stb[k]),
         .chatter     (chatter[k])
      );
   end

endmodule

// File: tb/tb_rpsc_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_rpsc_input_conditioner
// Directed scenarios plus a randomised phase, compared each cycle against a
// behavioural model of the conditioner (TEST_MODE: full scale 8).
// -----------------------------------------------------------------------------
module tb_rpsc_input_conditioner;
   import rpsc_pkg::*;

   localparam int N   = 14;
   localparam int TGT = 8;
   localparam logic [N-1:0] MASK = 14'h0104;

   logic         clk;
   logic         reset;
   logic [N-1:0] raw_in;
   logic [N-1:0] chatter_clr;
   logic [N-1:0] filt_out;
   logic [N-1:0] rise_stb;
   logic [N-1:0] fall_stb;
   logic [N-1:0] chatter;

   int checks = 0;
   int errors = 0;

   // Model state: sync pipeline, integrator value, last step sign, levels
   int m_s1[N], m_s2[N], m_cnt[N], m_dir[N], m_filt[N], m_chat[N];
   logic [N-1:0] e_rise, e_fall;

   rpsc_input_conditioner #(
      .N_CH        (N),
      .CNT_W       (32'd13),
      .FILT_TARGET (32'd7812),
      .LPF_MASK    (MASK),
      .TEST_MODE   (1'b1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .raw_in      (raw_in),
      .chatter_clr (chatter_clr),
      .filt_out    (filt_out),
      .rise_stb    (rise_stb),
      .fall_stb    (fall_stb),
      .chatter     (chatter)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_clear();
      for (int k = 0; k < N; k++) begin
         m_s1[k] = 0; m_s2[k] = 0; m_cnt[k] = 0; m_dir[k] = -1;
         m_filt[k] = 0; m_chat[k] = 0;
      end
      e_rise = '0;
      e_fall = '0;
   endtask

   // One clock edge of the reference behaviour
   task automatic model_edge();
      if (reset == 1'b0) begin
         model_clear();
      end else begin
         for (int k = 0; k < N; k++) begin
            int s2, stp, nc, nf;
            bit set;
            s2 = m_s2[k];
            set = 1'b0;
            if (MASK[k]) begin
               if (s2 == 1 && m_cnt[k] < TGT) stp = 1;
               else if (s2 == 0 && m_cnt[k] > 0) stp = -1;
               else stp = 0;
               set = (m_cnt[k] > 0) && (m_cnt[k] < TGT) && ((s2 == 1) != (m_dir[k] > 0));
               nc = m_cnt[k] + stp;
               if (stp != 0) m_dir[k] = stp;
               nf = (nc == TGT) ? 1 : ((nc == 0) ? 0 : m_filt[k]);
            end else begin
               nc = 0;
               nf = s2;
            end
            e_rise[k] = (nf == 1) && (m_filt[k] == 0);
            e_fall[k] = (nf == 0) && (m_filt[k] == 1);
            m_chat[k] = (set || (m_chat[k] == 1 && !chatter_clr[k])) ? 1 : 0;
            m_s2[k] = m_s1[k];
            m_s1[k] = raw_in[k];
            m_cnt[k] = nc;
            m_filt[k] = nf;
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [N-1:0] ef, ec;
      for (int k = 0; k < N; k++) begin
         ef[k] = (m_filt[k] != 0);
         ec[k] = (m_chat[k] != 0);
      end
      checks += 4;
      assert (filt_out === ef) else begin
         errors++; $error("FAIL %s filt_out observed=%h expected=%h", tag, filt_out, ef);
      end
      assert (rise_stb === e_rise) else begin
         errors++; $error("FAIL %s rise_stb observed=%h expected=%h", tag, rise_stb, e_rise);
      end
      assert (fall_stb === e_fall) else begin
         errors++; $error("FAIL %s fall_stb observed=%h expected=%h", tag, fall_stb, e_fall);
      end
      assert (chatter === ec) else begin
         errors++; $error("FAIL %s chatter observed=%h expected=%h", tag, chatter, ec);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++; $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Clock edge, model update, compare, then return at the falling edge
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
      @(negedge clk);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   initial begin
      logic [N-1:0] flip, clr;
      reset = 1'b0;
      raw_in = '0;
      chatter_clr = '0;
      model_clear();

      // 1. Reset held 3 cycles, then clean step on G2_PS_ACT
      idle(3, "in_reset");
      reset = 1'b1;
      #1;
      check_all("post_reset");
      raw_in[CH_I27_G2_PS_ACT] = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         step("t1_step");
         if (e == 9)  check_bit("t1_e9_filt", filt_out[8], 1'b0);
         if (e == 10) check_bit("t1_e10_filt", filt_out[8], 1'b1);
         if (e == 10) check_bit("t1_e10_rise", rise_stb[8], 1'b1);
         if (e == 11) check_bit("t1_e11_rise", rise_stb[8], 1'b0);
      end
      check_bit("t1_chatter", chatter[8], 1'b0);

      // 2. Return low cleanly, then a 3-cycle glitch
      raw_in[8] = 1'b0;
      idle(14, "t2_fall");
      raw_in[8] = 1'b1;
      idle(3, "t2_glitch_hi");
      raw_in[8] = 1'b0;
      for (int e = 0; e < 15; e++) begin
         step("t2_decay");
         check_bit("t2_filt_low", filt_out[8], 1'b0);
      end
      check_bit("t2_chatter_set", chatter[8], 1'b1);
      chatter_clr[8] = 1'b1;
      step("t2_clr");
      chatter_clr[8] = 1'b0;
      check_bit("t2_chatter_cleared", chatter[8], 1'b0);

      // 3. Bypass channel follows after 3 edges
      raw_in[CH_I4_U_G2_LOW] = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         step("t3_bypass");
         if (e == 2) check_bit("t3_e2_filt", filt_out[0], 1'b0);
         if (e == 3) check_bit("t3_e3_filt", filt_out[0], 1'b1);
         if (e == 3) check_bit("t3_e3_rise", rise_stb[0], 1'b1);
         if (e == 4) check_bit("t3_e4_rise", rise_stb[0], 1'b0);
      end
      check_bit("t3_chatter", chatter[0], 1'b0);

      // 4. DR_AMP saturated for 30 cycles, then released
      raw_in[CH_I59_DR_AMP] = 1'b1;
      idle(30, "t4_sat");
      raw_in[2] = 1'b0;
      for (int e = 1; e <= 11; e++) begin
         step("t4_release");
         if (e == 9)  check_bit("t4_e9_filt", filt_out[2], 1'b1);
         if (e == 10) check_bit("t4_e10_filt", filt_out[2], 1'b0);
         if (e == 10) check_bit("t4_e10_fall", fall_stb[2], 1'b1);
         if (e == 11) check_bit("t4_e11_fall", fall_stb[2], 1'b0);
      end
      idle(4, "t4_settle");

      // 5. Chatter set on the same edge as a clear request (set at edge 6)
      check_bit("t5_pre_chatter", chatter[8], 1'b0);
      raw_in[8] = 1'b1;
      idle(3, "t5_hi");
      raw_in[8] = 1'b0;
      idle(2, "t5_lo");
      chatter_clr[8] = 1'b1;
      step("t5_set_and_clr");
      chatter_clr[8] = 1'b0;
      check_bit("t5_set_wins", chatter[8], 1'b1);
      idle(12, "t5_decay");

      // Randomised phase with occasional clears
      for (int i = 0; i < 500; i++) begin
         flip = '0;
         clr = '0;
         for (int k = 0; k < N; k++) begin
            flip[k] = ($urandom_range(0, 11) == 0);
            clr[k]  = ($urandom_range(0, 15) == 0);
         end
         if (i % 100 < 40) flip = flip & ~MASK;
         raw_in = raw_in ^ flip;
         chatter_clr = clr;
         step("rand");
      end
      chatter_clr = '0;

      // 6. Asynchronous reset mid-count on G2_PS_ACT
      raw_in = '0;
      idle(20, "t6_quiet");
      raw_in[0] = 1'b1;
      raw_in[8] = 1'b1;
      idle(7, "t6_count");
      check_bit("t6_pre_filt0", filt_out[0], 1'b1);
      #2;
      reset = 1'b0;
      #1;
      checks += 4;
      assert (filt_out === '0) else begin
         errors++; $error("FAIL t6_async filt_out observed=%h expected=0", filt_out);
      end
      assert (rise_stb === '0) else begin
         errors++; $error("FAIL t6_async rise_stb observed=%h expected=0", rise_stb);
      end
      assert (fall_stb === '0) else begin
         errors++; $error("FAIL t6_async fall_stb observed=%h expected=0", fall_stb);
      end
      assert (chatter === '0) else begin
         errors++; $error("FAIL t6_async chatter observed=%h expected=0", chatter);
      end
      model_clear();
      @(negedge clk);
      idle(2, "t6_in_reset");
      reset = 1'b1;
      for (int e = 1; e <= 11; e++) begin
         step("t6_restep");
         if (e == 9)  check_bit("t6_e9_filt", filt_out[8], 1'b0);
         if (e == 10) check_bit("t6_e10_filt", filt_out[8], 1'b1);
         if (e == 10) check_bit("t6_e10_rise", rise_stb[8], 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
